// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: baud divisors for a 50 MHz system
//                clock and the receiver/transmitter FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // sys_clk cycles per bit at 50 MHz
  localparam logic [15:0] BPS_115200 = 16'd434;
  localparam logic [15:0] BPS_9600   = 16'd5208;

  // Frame sequencing states shared by uart_recv and uart_send
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_recv_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_recv_if
//  Description : Received-byte interface. The receiver drives it through the
//                master modport; the command/loopback logic reads it through
//                the slave modport (maps 1:1 onto uart_send's byte inputs).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_recv_if;
  import uart_pkg::*;

  logic [7:0] rx_byte;       // last good byte, held until next good frame
  logic       rx_byte_vld;   // 1-cycle strobe: rx_byte updated
  logic       rx_frame_err;  // 1-cycle strobe: stop bit low, byte dropped
  logic       rx_busy;       // frame in progress

  modport master (
    output rx_byte,
    output rx_byte_vld,
    output rx_frame_err,
    output rx_busy
  );

  modport slave (
    input rx_byte,
    input rx_byte_vld,
    input rx_frame_err,
    input rx_busy
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : Two-flop synchroniser for the asynchronous serial input plus
//                one delay flop for falling-edge detection. All flops reset to
//                1 (line idle) so reset release never produces a false edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic rxd_async,
  output logic rxd_s,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q,  dly_d;

  // Shift the line one stage per clock through the synchroniser chain
  always_comb begin
    meta_d = rxd_async;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  // Chain registers, idle-high after reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rxd_s = sync_q;
  assign fall  = dly_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_recv.sv
`default_nettype none
// ============================================================================
//  Module      : uart_recv
//  Description : 8N1 UART receiver, LSB first. Validates the start bit at its
//                midpoint, samples each data bit at mid-bit and reports either
//                a good byte (1-cycle strobe) or a framing error.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_recv
  import uart_pkg::*;
#(
  parameter logic [15:0] BPS_CNT = BPS_115200  // sys_clk cycles per bit, >= 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  uart_recv_if.master rx_if
);

  localparam logic [15:0] HALF_LAST = (BPS_CNT / 16'd2) - 16'd1;
  localparam logic [15:0] FULL_LAST = BPS_CNT - 16'd1;

  logic rxd_s;
  logic fall;

  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rxd_async (uart_rxd),
    .rxd_s     (rxd_s),
    .fall      (fall)
  );

  uart_state_e state_q,   state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q,   shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        vld_q,     vld_d;
  logic        err_q,     err_d;

  // Next-state logic: frame sequencing, bit timing and data shifting
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_byte_d = rx_byte_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Only a true high-to-low transition starts a frame; a line that is
        // merely low (break, or low after a framing error) is ignored.
        if (fall) begin
          clk_cnt_d = 16'd0;
          state_d   = ST_START;
        end
      end

      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          if (rxd_s) begin
            state_d = ST_IDLE;  // glitch shorter than half a bit
          end else begin
            clk_cnt_d = 16'd0;
            bit_cnt_d = 3'd0;
            state_d   = ST_DATA;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == FULL_LAST) begin
          shift_d   = {rxd_s, shift_q[7:1]};
          clk_cnt_d = 16'd0;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      ST_STOP: begin
        // Leave at mid-stop so a back-to-back start edge is never missed
        if (clk_cnt_q == FULL_LAST) begin
          state_d = ST_IDLE;
          if (rxd_s) begin
            rx_byte_d = shift_q;
            vld_d     = 1'b1;
          end else begin
            err_d     = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; reset drops any partial frame
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      rx_byte_q <= 8'd0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_byte_q <= rx_byte_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign rx_if.rx_byte      = rx_byte_q;
  assign rx_if.rx_byte_vld  = vld_q;
  assign rx_if.rx_frame_err = err_q;
  assign rx_if.rx_busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_recv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_recv
//  Description : Self-checking bench for uart_recv. Instance 0 runs at 16
//                cycles/bit for the directed cases; instance 1 runs at 434
//                cycles/bit and is fed by an ideal transmitter at nominal and
//                +/-3% baud. A queue of transmitted frames is the reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_recv;
  import uart_pkg::*;

  localparam int B0 = 16;
  localparam int B1 = 434;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rxd [2];

  uart_recv_if uif0 ();
  uart_recv_if uif1 ();

  uart_recv #(.BPS_CNT(16'd16)) dut0 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .uart_rxd  (rxd[0]),
    .rx_if     (uif0)
  );

  uart_recv #(.BPS_CNT(BPS_115200)) dut1 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .uart_rxd  (rxd[1]),
    .rx_if     (uif1)
  );

  logic [7:0] o_byte [2];
  logic       o_vld  [2];
  logic       o_err  [2];
  logic       o_busy [2];
  assign o_byte[0] = uif0.rx_byte;      assign o_byte[1] = uif1.rx_byte;
  assign o_vld[0]  = uif0.rx_byte_vld;  assign o_vld[1]  = uif1.rx_byte_vld;
  assign o_err[0]  = uif0.rx_frame_err; assign o_err[1]  = uif1.rx_frame_err;
  assign o_busy[0] = uif0.rx_busy;      assign o_busy[1] = uif1.rx_busy;

  int total = 0;
  int bad   = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: every frame the bench sends with intent to be received
  typedef struct {
    bit         err;
    logic [7:0] b;
    longint     t0;
  } exp_t;

  exp_t       expq  [2][$];
  longint     vld_t [2][$];
  logic [7:0] model_byte [2];
  exp_t       e;

  function automatic int bps_of(input int i);
    return (i == 0) ? B0 : B1;
  endfunction

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference frame-to-pulse distance: 2 sync + edge + half start + 8 data + stop
  function automatic void check_lat(input string name, input longint d, input int b);
    longint l;
    l = 3 + b / 2 + 9 * b;
    total++;
    if (d < l - 1 || d > l + 1) begin
      bad++;
      $display("FAIL %s: latency %0d, expected %0d +/-1", name, d, l);
    end
  endfunction

  // Compare process: outputs against the frame queue on every cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        check("reset_outputs", {o_byte[i], o_vld[i], o_err[i], o_busy[i]}, 0);
        model_byte[i] = 8'h00;
        continue;
      end
      if (o_vld[i] && o_err[i]) check("vld_err_exclusive", 1, 0);
      if (o_vld[i] || o_err[i]) begin
        if (expq[i].size() == 0) begin
          check(o_vld[i] ? "unexpected_vld" : "unexpected_err", 1, 0);
        end else begin
          e = expq[i].pop_front();
          check("pulse_kind_err", o_err[i], e.err);
          check_lat("pulse_latency", cyc - e.t0, bps_of(i));
          if (o_vld[i]) begin
            check("rx_byte_on_vld", o_byte[i], e.b);
            model_byte[i] = e.b;
            vld_t[i].push_back(cyc);
          end
        end
      end
      check("rx_byte_hold", o_byte[i], model_byte[i]);
    end
  end

  // Ideal transmitter: start, 8 data LSB first, stop; blen cycles per bit
  task automatic send(input int i, input logic [7:0] b, input logic stop,
                      input int blen, input bit expect_it);
    logic [9:0] bits;
    exp_t x;
    bits = {stop, b, 1'b0};
    if (expect_it) begin
      x.err = ~stop;
      x.b   = b;
      x.t0  = cyc;
      expq[i].push_back(x);
    end
    for (int k = 0; k < 10; k++) begin
      rxd[i] = bits[k];
      repeat (blen) @(negedge clk);
    end
  endtask

  task automatic line(input int i, input logic v, input int n);
    rxd[i] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int i, input string name);
    int n;
    n = 0;
    while (expq[i].size() != 0 && n < 2 * bps_of(i)) begin
      @(negedge clk);
      n++;
    end
    check(name, expq[i].size(), 0);
    expq[i].delete();
  endtask

  initial begin
    rst_n  = 1'b1;
    rxd[0] = 1'b1;
    rxd[1] = 1'b1;
    #2 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    line(0, 1'b1, 20);
    check("reset_state_byte", o_byte[0], 8'h00);
    check("reset_state_busy", o_busy[0], 0);
    check("reset_state_vld",  o_vld[0], 0);

    // 1: single frame
    vld_t[0].delete();
    send(0, 8'h55, 1'b1, B0, 1'b1);
    line(0, 1'b1, 20);
    drain(0, "t1_drain");
    check("t1_byte", o_byte[0], 8'h55);
    check("t1_vld_count", vld_t[0].size(), 1);

    // 2: back-to-back frames, no idle gap
    vld_t[0].delete();
    send(0, 8'hA5, 1'b1, B0, 1'b1);
    send(0, 8'h3C, 1'b1, B0, 1'b1);
    line(0, 1'b1, 20);
    drain(0, "t2_drain");
    check("t2_vld_count", vld_t[0].size(), 2);
    if (vld_t[0].size() == 2) check("t2_spacing", vld_t[0][1] - vld_t[0][0], 10 * B0);
    check("t2_byte", o_byte[0], 8'h3C);

    // 3: short low glitch must not start a frame
    line(0, 1'b0, B0 / 2 - 2);
    line(0, 1'b1, 30);
    check("t3_busy_after_glitch", o_busy[0], 0);
    send(0, 8'h81, 1'b1, B0, 1'b1);
    line(0, 1'b1, 20);
    drain(0, "t3_drain");
    check("t3_byte", o_byte[0], 8'h81);

    // 4: framing error, then held-low line, then a good frame
    send(0, 8'hF0, 1'b0, B0, 1'b1);
    line(0, 1'b0, 3 * B0);
    drain(0, "t4_err_drain");
    check("t4_byte_kept", o_byte[0], 8'h81);
    check("t4_busy_low_line", o_busy[0], 0);
    line(0, 1'b1, 2 * B0);
    send(0, 8'h12, 1'b1, B0, 1'b1);
    line(0, 1'b1, 20);
    drain(0, "t4_drain");
    check("t4_byte", o_byte[0], 8'h12);

    // 5: reset during data bit 4, released during the stop bit
    fork
      send(0, 8'h77, 1'b1, B0, 1'b0);
      begin
        repeat (5 * B0 + 8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_byte", o_byte[0], 8'h00);
        check("t5_rst_busy", o_busy[0], 0);
        check("t5_rst_vld",  o_vld[0], 0);
        check("t5_rst_err",  o_err[0], 0);
        repeat (9 * B0 + 6 - (5 * B0 + 8)) @(negedge clk);
        #2 rst_n = 1'b1;
      end
    join
    line(0, 1'b1, 40);
    check("t5_busy_after_release", o_busy[0], 0);
    send(0, 8'h09, 1'b1, B0, 1'b1);
    line(0, 1'b1, 20);
    drain(0, "t5_drain");
    check("t5_byte", o_byte[0], 8'h09);

    // 6: 115200 link at nominal, +3% and -3% transmitter baud
    for (int r = 0; r < 3; r++) begin
      int blen;
      blen = (r == 0) ? B1 : (r == 1) ? 447 : 421;
      send(1, 8'h00, 1'b1, blen, 1'b1);
      send(1, 8'hFF, 1'b1, blen, 1'b1);
      send(1, 8'h5A, 1'b1, blen, 1'b1);
      line(1, 1'b1, 100);
      drain(1, "t6_drain");
      check("t6_last_byte", o_byte[1], 8'h5A);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on the whole run
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL timeout: run exceeded time limit at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
